adc_scan_ctrl: RTL and testbench

Channel scheduler for the serial 10-bit ADC interface in the health monitoring datapath. Scans the enabled analog channels (ECG, temperature, SpO2, …) once per sample period, issues one conversion request per channel to the ADC serial engine, and tags each returned word with its channel. It also accepts one-shot software requests, which take priority over the scan, and flags conversions that never complete.

---
 rtl/adc_scan_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl
//   Channel scheduler for the serial 10-bit ADC engine. Once per PERIOD
//   cycles it latches ch_en into a round mask and converts every enabled
//   channel, lowest index first. One-shot software requests are queued
//   (one deep) and jump ahead of the scan. Conversions that never complete
//   are abandoned after TIMEOUT cycles.
//
//   Optional feature: define ADC_SCAN_THRESH_EN to add per-channel
//   upper/lower limit registers and the alarm flags. Without it alarm is 0
//   and the threshold inputs are unused.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   scan_go, ch_en    periodic scan enable, per-channel enable mask
//   sw_req, sw_ch     one-shot request and its channel; sw_ack on accept
//   adc_start/ch/sgl  conversion request to the serial engine
//   adc_done/data     engine completion pulse and result
//   sample_*          delivered sample (valid pulse, channel, data)
//   round_done        pulse after the last channel of a round
//   busy              converting or selecting (not IDLE / WAIT_TICK)
//   overrun           sticky: a round outlasted PERIOD
//   timeout_err       sticky: a conversion was abandoned
//   thr_wr/ch/hi/lo   threshold register write port
//   alarm             per-channel out-of-range flags
module adc_scan_ctrl #(
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_go,
  input  logic [7:0] ch_en,
  input  logic       sw_req,
  input  logic [2:0] sw_ch,
  output logic       adc_start,
  output logic [2:0] adc_ch,
  output logic       adc_sgl,
  input  logic       adc_done,
  input  logic [9:0] adc_data,
  output logic       sample_valid,
  output logic [2:0] sample_ch,
  output logic [9:0] sample_data,
  output logic       sw_ack,
  output logic       round_done,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err,
  input  logic       thr_wr,
  input  logic [2:0] thr_ch,
  input  logic [9:0] thr_hi,
  input  logic [9:0] thr_lo,
  output logic [7:0] alarm
);

  localparam int CW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] PER_M1 = CW'(PERIOD - 1);
  localparam logic [TW-1:0] TO_M1  = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_TICK = 3'd1;
  localparam logic [2:0] S_SELECT    = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    mask;
  logic          sw_pend;
  logic [2:0]    sw_ch_q;
  logic          tick_pend;
  logic          round_last;
  logic          tick;
  logic [2:0]    sel_ch;
  logic          mask_last;

  // Index of the lowest set bit; the caller guarantees a nonzero mask.
  function automatic logic [2:0] low_bit(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign tick      = (state != S_IDLE) && (per_cnt == PER_M1);
  assign sel_ch    = low_bit(mask);
  assign mask_last = ((mask & (mask - 8'd1)) == 8'd0);
  assign sw_ack    = sw_req & ~sw_pend & ~rst;
  assign busy      = (state != S_IDLE) && (state != S_WAIT_TICK);
  assign adc_sgl   = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      per_cnt      <= '0;
      to_cnt       <= '0;
      mask         <= 8'd0;
      sw_pend      <= 1'b0;
      sw_ch_q      <= 3'd0;
      tick_pend    <= 1'b0;
      round_last   <= 1'b0;
      adc_start    <= 1'b0;
      adc_ch       <= 3'd0;
      sample_valid <= 1'b0;
      sample_ch    <= 3'd0;
      sample_data  <= 10'd0;
      round_done   <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      adc_start    <= 1'b0;
      sample_valid <= 1'b0;
      round_done   <= 1'b0;

      if (state == S_IDLE || tick) per_cnt <= '0;
      else                         per_cnt <= per_cnt + CW'(1);

      if (sw_ack) begin
        sw_pend <= 1'b1;
        sw_ch_q <= sw_ch;
      end

      // A tick that finds the scheduler still busy is remembered so the
      // next round begins as soon as the current one finishes.
      if (tick && state != S_WAIT_TICK) begin
        overrun   <= 1'b1;
        tick_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          tick_pend <= 1'b0;
          if (sw_pend)      state <= S_SELECT;
          else if (scan_go) state <= S_WAIT_TICK;
        end

        S_WAIT_TICK: begin
          if (tick || tick_pend) begin
            mask      <= ch_en;
            tick_pend <= 1'b0;
            state     <= S_SELECT;
          end else if (sw_pend) begin
            state <= S_SELECT;
          end else if (!scan_go) begin
            state <= S_IDLE;
          end
        end

        S_SELECT: begin
          if (sw_pend) begin
            adc_ch    <= sw_ch_q;
            adc_start <= 1'b1;
            sw_pend   <= 1'b0;
            if (!scan_go) mask <= 8'd0;
            state     <= S_ISSUE;
          end else if (scan_go && mask != 8'd0) begin
            adc_ch       <= sel_ch;
            adc_start    <= 1'b1;
            mask[sel_ch] <= 1'b0;
            round_last   <= mask_last;
            state        <= S_ISSUE;
          end else begin
            // Nothing left to convert, or scanning was withdrawn mid-round.
            mask <= 8'd0;
            if (scan_go) begin
              state <= S_WAIT_TICK;
            end else begin
              tick_pend <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end

        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (adc_done) begin
            sample_valid <= 1'b1;
            sample_ch    <= adc_ch;
            sample_data  <= adc_data;
            round_done   <= round_last;
            round_last   <= 1'b0;
            state        <= S_SELECT;
          end else if (to_cnt == TO_M1) begin
            timeout_err <= 1'b1;
            round_done  <= round_last;
            round_last  <= 1'b0;
            state       <= S_SELECT;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADC_SCAN_THRESH_EN
  logic [9:0] thr_hi_r [8];
  logic [9:0] thr_lo_r [8];
  logic [7:0] alarm_r;

  // The flag is computed from the engine word so that it changes on the
  // same edge that raises sample_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        thr_hi_r[i] <= 10'h3FF;
        thr_lo_r[i] <= 10'h000;
      end
      alarm_r <= 8'd0;
    end else begin
      if (thr_wr) begin
        thr_hi_r[thr_ch] <= thr_hi;
        thr_lo_r[thr_ch] <= thr_lo;
      end
      if (state == S_WAIT_DONE && adc_done) begin
        alarm_r[adc_ch] <= (adc_data > thr_hi_r[adc_ch]) ||
                           (adc_data < thr_lo_r[adc_ch]);
      end
    end
  end

  assign alarm = alarm_r;
`else
  logic unused_thr;
  assign unused_thr = ^{thr_wr, thr_ch, thr_hi, thr_lo};
  assign alarm      = 8'h00;
`endif

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl (PERIOD=200, TIMEOUT=64). A behavioural
// ADC engine answers each adc_start after eng_lat cycles with eng_data[ch];
// a monitor logs starts, samples and round_done with cycle stamps.
module tb_adc_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       scan_go;
  logic [7:0] ch_en;
  logic       sw_req;
  logic [2:0] sw_ch;
  logic       adc_start;
  logic [2:0] adc_ch;
  logic       adc_sgl;
  logic       adc_done;
  logic [9:0] adc_data;
  logic       sample_valid;
  logic [2:0] sample_ch;
  logic [9:0] sample_data;
  logic       sw_ack;
  logic       round_done;
  logic       busy;
  logic       overrun;
  logic       timeout_err;
  logic       thr_wr;
  logic [2:0] thr_ch;
  logic [9:0] thr_hi;
  logic [9:0] thr_lo;
  logic [7:0] alarm;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int eng_lat = 20;
  int eng_silent = -1;
  bit eng_on = 1'b1;
  bit stray_req = 1'b0;
  int eng_data [8];

  int st_ch [$];
  int st_cyc [$];
  int s_ch [$];
  int s_data [$];
  int s_cyc [$];
  logic [7:0] s_al [$];
  int d_cyc [$];
  int rd_cyc [$];
  int ack_cnt;
  int te_cyc;
  int ov_cyc;

  adc_scan_ctrl #(.PERIOD(200), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .scan_go(scan_go), .ch_en(ch_en),
    .sw_req(sw_req), .sw_ch(sw_ch),
    .adc_start(adc_start), .adc_ch(adc_ch), .adc_sgl(adc_sgl),
    .adc_done(adc_done), .adc_data(adc_data),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .sw_ack(sw_ack), .round_done(round_done), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err),
    .thr_wr(thr_wr), .thr_ch(thr_ch), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .alarm(alarm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model
  initial begin
    int ch;
    adc_done = 1'b0;
    adc_data = 10'd0;
    forever begin
      @(posedge clk); #1;
      if (stray_req) begin
        stray_req = 1'b0;
        adc_done = 1'b1;
        adc_data = 10'h155;
        @(posedge clk); #1;
        adc_done = 1'b0;
      end else if (adc_start && eng_on && !rst && int'(adc_ch) != eng_silent) begin
        ch = int'(adc_ch);
        repeat (eng_lat) @(posedge clk);
        #1;
        adc_done = 1'b1;
        adc_data = 10'(eng_data[ch]);
        d_cyc.push_back(cyc);
        @(posedge clk); #1;
        adc_done = 1'b0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (adc_start) begin
      st_ch.push_back(int'(adc_ch));
      st_cyc.push_back(cyc);
    end
    if (sample_valid) begin
      s_ch.push_back(int'(sample_ch));
      s_data.push_back(int'(sample_data));
      s_cyc.push_back(cyc);
      s_al.push_back(alarm);
    end
    if (round_done) rd_cyc.push_back(cyc);
    if (sw_ack) ack_cnt++;
    if (timeout_err && te_cyc < 0) te_cyc = cyc;
    if (overrun && ov_cyc < 0) ov_cyc = cyc;
  end

  function automatic logic [30:0] out_vec();
    return {adc_start, adc_ch, sample_valid, sample_ch, sample_data, sw_ack,
            round_done, busy, overrun, timeout_err, alarm};
  endfunction

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    st_ch.delete(); st_cyc.delete();
    s_ch.delete(); s_data.delete(); s_cyc.delete(); s_al.delete();
    d_cyc.delete(); rd_cyc.delete();
    ack_cnt = 0; te_cyc = -1; ov_cyc = -1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    scan_go = 1'b0; ch_en = 8'd0; sw_req = 1'b0; sw_ch = 3'd0;
    thr_wr = 1'b0; thr_ch = 3'd0; thr_hi = 10'd0; thr_lo = 10'd0;
    eng_on = 1'b1; eng_silent = -1; eng_lat = 20;
    for (int i = 0; i < 8; i++) eng_data[i] = i * 100;
    tick_wait(3);
    rst = 1'b0;
    tick_wait(1);
    clear_logs();
  endtask

  // which: 0 = adc_start count, 1 = sample count, 2 = round_done count
  task automatic wait_count(input string name, input int which, input int n, input int budget);
    int k;
    int got;
    k = 0;
    got = (which == 0) ? st_ch.size() : (which == 1) ? s_ch.size() : rd_cyc.size();
    while (got < n && k < budget) begin
      tick_wait(1);
      k++;
      got = (which == 0) ? st_ch.size() : (which == 1) ? s_ch.size() : rd_cyc.size();
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL %s: count %0d after %0d cycles, required %0d", name, got, budget, n);
    end
  endtask

  task automatic end_test();
    int k;
    scan_go = 1'b0;
    k = 0;
    while (busy && k < 300) begin
      tick_wait(1);
      k++;
    end
    tick_wait(5);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scan_go = 1'b0; ch_en = 8'd0; sw_req = 1'b0; sw_ch = 3'd0;
    thr_wr = 1'b0; thr_ch = 3'd0; thr_hi = 10'd0; thr_lo = 10'd0;
    for (int i = 0; i < 8; i++) eng_data[i] = i * 100;
    tick_wait(3);
    checks++;
    if (out_vec() !== 31'd0) begin
      errors++; $display("FAIL reset_outputs: got %h, required 0", out_vec());
    end
    checks++;
    if (adc_sgl !== 1'b1) begin
      errors++; $display("FAIL reset_sgl: got %b, required 1", adc_sgl);
    end
    rst = 1'b0;
    clear_logs();
    tick_wait(300);
    checks++;
    if (out_vec() !== 31'd0 || st_ch.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: outputs %h starts %0d, required 0 and 0", out_vec(), st_ch.size());
    end
  endtask

  task automatic test_basic_scan();
    int c0;
    apply_reset();
    c0 = cyc;
    ch_en = 8'b0000_0101;
    scan_go = 1'b1;
    tick_wait(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_wait_tick: got %b, required 0", busy);
    end
    wait_count("basic_samples", 1, 4, 700);
    checks++;
    if (st_cyc[0] - c0 != 202) begin
      errors++; $display("FAIL basic_first_start: at +%0d cycles, required +202", st_cyc[0] - c0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_ch[i] != (i % 2) * 2 || s_data[i] != (i % 2) * 200) begin
        errors++;
        $display("FAIL basic_sample%0d: got (%0d,%0d), required (%0d,%0d)",
                 i, s_ch[i], s_data[i], (i % 2) * 2, (i % 2) * 200);
      end
    end
    checks++;
    if (s_cyc[0] - d_cyc[0] != 1) begin
      errors++; $display("FAIL basic_valid_latency: %0d cycles after done, required 1", s_cyc[0] - d_cyc[0]);
    end
    checks++;
    if (rd_cyc.size() != 2 || rd_cyc[0] != s_cyc[1] || rd_cyc[1] - rd_cyc[0] != 200) begin
      errors++;
      $display("FAIL basic_round_done: count %0d first %0d spacing %0d, required 2, %0d, 200",
               rd_cyc.size(), rd_cyc[0], rd_cyc[1] - rd_cyc[0], s_cyc[1]);
    end
    end_test();
  endtask

  task automatic test_sw_priority();
    int exp_ch [9] = '{0, 5, 1, 2, 3, 4, 5, 6, 7};
    apply_reset();
    ch_en = 8'hFF;
    scan_go = 1'b1;
    wait_count("sw_first_start", 0, 1, 400);
    tick_wait(5);
    sw_req = 1'b1; sw_ch = 3'd5;
    #1;
    checks++;
    if (sw_ack !== 1'b1) begin
      errors++; $display("FAIL sw_ack_first: got %b, required 1", sw_ack);
    end
    tick_wait(1);
    sw_req = 1'b1; sw_ch = 3'd2;
    #1;
    checks++;
    if (sw_ack !== 1'b0) begin
      errors++; $display("FAIL sw_ack_pending: got %b, required 0", sw_ack);
    end
    tick_wait(1);
    sw_req = 1'b0;
    wait_count("sw_starts", 0, 9, 400);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (st_ch[i] != exp_ch[i]) begin
        errors++; $display("FAIL sw_order%0d: channel %0d, required %0d", i, st_ch[i], exp_ch[i]);
      end
    end
    checks++;
    if (s_ch[1] != 5 || s_data[1] != 500) begin
      errors++; $display("FAIL sw_sample: got (%0d,%0d), required (5,500)", s_ch[1], s_data[1]);
    end
    checks++;
    if (ack_cnt != 1) begin
      errors++; $display("FAIL sw_ack_count: got %0d, required 1", ack_cnt);
    end
    end_test();
  endtask

  task automatic test_timeout();
    apply_reset();
    eng_silent = 3;
    ch_en = 8'b0001_1000;
    scan_go = 1'b1;
    wait_count("to_starts", 0, 2, 600);
    wait_count("to_samples", 1, 1, 100);
    tick_wait(10);
    checks++;
    if (st_ch[0] != 3 || st_ch[1] != 4) begin
      errors++; $display("FAIL to_order: got %0d,%0d, required 3,4", st_ch[0], st_ch[1]);
    end
    checks++;
    if (te_cyc - st_cyc[0] != 65) begin
      errors++; $display("FAIL to_flag_time: +%0d cycles after start, required +65", te_cyc - st_cyc[0]);
    end
    checks++;
    if (st_cyc[1] - st_cyc[0] != 66) begin
      errors++; $display("FAIL to_next_issue: +%0d cycles, required +66", st_cyc[1] - st_cyc[0]);
    end
    checks++;
    if (s_ch.size() != 1 || s_ch[0] != 4 || s_data[0] != 400) begin
      errors++;
      $display("FAIL to_samples: %0d samples first (%0d,%0d), required 1 sample (4,400)",
               s_ch.size(), s_ch[0], s_data[0]);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b, required 1", timeout_err);
    end
    end_test();
  endtask

  task automatic test_overrun();
    apply_reset();
    eng_lat = 30;
    ch_en = 8'hFF;
    scan_go = 1'b1;
    wait_count("ovr_starts", 0, 9, 800);
    checks++;
    if (ov_cyc - st_cyc[0] != 199) begin
      errors++; $display("FAIL ovr_flag_time: +%0d cycles after first start, required +199", ov_cyc - st_cyc[0]);
    end
    checks++;
    if (rd_cyc.size() < 1 || rd_cyc[0] - st_cyc[0] != 255) begin
      errors++; $display("FAIL ovr_round_done: +%0d cycles, required +255", rd_cyc[0] - st_cyc[0]);
    end
    checks++;
    if (st_ch[8] != 0 || st_cyc[8] - rd_cyc[0] != 3) begin
      errors++;
      $display("FAIL ovr_next_round: ch %0d at +%0d after round_done, required ch 0 at +3",
               st_ch[8], st_cyc[8] - rd_cyc[0]);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got %b, required 1", overrun);
    end
    end_test();
  endtask

  task automatic test_reset_stray();
    apply_reset();
    eng_on = 1'b0;
    ch_en = 8'h01;
    scan_go = 1'b1;
    wait_count("rs_start", 0, 1, 400);
    tick_wait(5);
    rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== 31'd0 || adc_sgl !== 1'b1) begin
      errors++; $display("FAIL rs_async: outputs %h sgl %b, required 0 and 1", out_vec(), adc_sgl);
    end
    scan_go = 1'b0;
    tick_wait(1);
    rst = 1'b0;
    clear_logs();
    stray_req = 1'b1;
    tick_wait(10);
    checks++;
    if (s_ch.size() != 0 || st_ch.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rs_stray_done: samples %0d starts %0d busy %b, required 0 0 0",
               s_ch.size(), st_ch.size(), busy);
    end
  endtask

  task automatic test_thresholds();
    logic exp_hi;
    apply_reset();
`ifdef ADC_SCAN_THRESH_EN
    exp_hi = 1'b1;
`else
    exp_hi = 1'b0;
`endif
    thr_wr = 1'b1; thr_ch = 3'd1; thr_hi = 10'd600; thr_lo = 10'd100;
    tick_wait(1);
    thr_wr = 1'b0;
    eng_data[1] = 700;
    ch_en = 8'h02;
    scan_go = 1'b1;
    wait_count("thr_sample1", 1, 1, 500);
    eng_data[1] = 300;
    wait_count("thr_sample2", 1, 2, 400);
    checks++;
    if (s_al[0] !== {6'd0, exp_hi, 1'b0}) begin
      errors++; $display("FAIL thr_alarm_700: got %b, required %b", s_al[0], {6'd0, exp_hi, 1'b0});
    end
    checks++;
    if (s_al[1] !== 8'd0) begin
      errors++; $display("FAIL thr_alarm_300: got %b, required 00000000", s_al[1]);
    end
    end_test();
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic_scan();
    test_sw_priority();
    test_timeout();
    test_overrun();
    test_reset_stray();
    test_thresholds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
